// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and bit-period helper for uart_echo_fifo.
// The PARITY state exists only when UART_ECHO_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_ECHO_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_state_e;

  function automatic int calc_div(input longint clk_hz, input longint baud);
    return int'(clk_hz / baud);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with first-word-fall-through read data.
// A push while full is ignored; fullness is taken from occupancy before any same-cycle pop.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally at DEPTH; the extra count bit separates full from empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: UART receiver -> FIFO -> UART transmitter loopback with sticky error flags.
// Define UART_ECHO_PARITY_EN to add a parity bit on both RX and TX and enable rx_parity_err.
module uart_echo_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter int DATA_BITS       = 8,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH      = 16,
  parameter int PARITY_ODD      = 0
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          rxd,
  output logic                          txd,
  input  logic                          tx_hold,
  input  logic                          err_clr,
  output logic                          rx_overrun,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int DIV  = calc_div(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int CW   = $clog2(STOP_BITS * DIV + 1);
  localparam int BW   = $clog2(DATA_BITS);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
`ifdef UART_ECHO_PARITY_EN
  localparam uart_state_e AFTER_DATA = PARITY;
`else
  localparam uart_state_e AFTER_DATA = STOP;
`endif

  logic                 rxd_meta, rxd_sync, rxd_prev, armed;
  logic [CW-1:0]        arm_cnt;
  uart_state_e          rx_state, rx_state_n, tx_state, tx_state_n;
  logic [CW-1:0]        rx_cnt, tx_cnt;
  logic [BW-1:0]        rx_bit, tx_bit;
  logic [DATA_BITS-1:0] rx_shift, tx_shift, fifo_dout;
  logic                 rx_tick, stop_tick, rx_push, frame_evt, parity_bad;
  logic                 tx_tick, tx_pop, txd_n, fifo_full, fifo_empty;
`ifdef UART_ECHO_PARITY_EN
  logic                 rx_par, tx_par, parity_evt;
`endif

  // Synchronizer; RX only arms after one full bit period of idle-high line.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
      armed    <= 1'b0;
      arm_cnt  <= '0;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
      if (!rxd_sync) arm_cnt <= '0;
      else if (!armed) begin
        if (arm_cnt == DIV_LAST) armed <= 1'b1;
        arm_cnt <= arm_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_tick    = 1'b0;
    case (rx_state)
      IDLE:  if (armed && rxd_prev && !rxd_sync) rx_state_n = START;
      START: if (rx_cnt == HALF_LAST) begin
               rx_tick    = 1'b1;
               rx_state_n = rxd_sync ? IDLE : DATA;
             end
      DATA:  if (rx_cnt == DIV_LAST) begin
               rx_tick = 1'b1;
               if (rx_bit == BIT_LAST) rx_state_n = AFTER_DATA;
             end
`ifdef UART_ECHO_PARITY_EN
      PARITY: if (rx_cnt == DIV_LAST) begin
                rx_tick    = 1'b1;
                rx_state_n = STOP;
              end
`endif
      STOP:  if (rx_cnt == DIV_LAST) begin
               rx_tick    = 1'b1;
               rx_state_n = IDLE;
             end
      default: rx_state_n = IDLE;
    endcase
  end

  assign stop_tick = rx_tick && (rx_state == STOP);
`ifdef UART_ECHO_PARITY_EN
  assign parity_bad = ((^rx_shift) ^ rx_par) != 1'(PARITY_ODD);
`else
  assign parity_bad = 1'b0;
`endif

  // Stop-sample outcome is registered, so the push lands one cycle after the sample.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rx_state  <= IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_push   <= 1'b0;
      frame_evt <= 1'b0;
    end else begin
      rx_state  <= rx_state_n;
      rx_cnt    <= (rx_tick || rx_state == IDLE) ? '0 : rx_cnt + 1'b1;
      if (rx_state == START) rx_bit <= '0;
      else if (rx_state == DATA && rx_tick) rx_bit <= rx_bit + 1'b1;
      rx_push   <= stop_tick && rxd_sync && !parity_bad;
      frame_evt <= stop_tick && !rxd_sync;
    end
  end

  always_ff @(posedge CLK) begin
    if (rx_state == DATA && rx_tick) rx_shift <= {rxd_sync, rx_shift[DATA_BITS-1:1]};
`ifdef UART_ECHO_PARITY_EN
    if (rx_state == PARITY && rx_tick) rx_par <= rxd_sync;
`endif
  end

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (rx_push),
    .din   (rx_shift),
    .pop   (tx_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A new error in the err_clr cycle wins over the clear.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_overrun   <= (rx_overrun && !err_clr) || (rx_push && fifo_full);
      rx_frame_err <= (rx_frame_err && !err_clr) || frame_evt;
    end
  end

`ifdef UART_ECHO_PARITY_EN
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      parity_evt    <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      parity_evt    <= stop_tick && rxd_sync && parity_bad;
      rx_parity_err <= (rx_parity_err && !err_clr) || parity_evt;
    end
  end
`else
  assign rx_parity_err = 1'b0;
`endif

  // txd_n is the line level for the next cycle; tx_shift[1] is the next bit because the shift happens on the same tick.
  always_comb begin
    tx_state_n = tx_state;
    tx_tick    = 1'b0;
    tx_pop     = 1'b0;
    txd_n      = txd;
    case (tx_state)
      IDLE:  if (!fifo_empty && !tx_hold) begin
               tx_pop     = 1'b1;
               tx_state_n = START;
               txd_n      = 1'b0;
             end
      START: if (tx_cnt == DIV_LAST) begin
               tx_tick    = 1'b1;
               tx_state_n = DATA;
               txd_n      = tx_shift[0];
             end
      DATA:  if (tx_cnt == DIV_LAST) begin
               tx_tick = 1'b1;
               if (tx_bit == BIT_LAST) begin
                 tx_state_n = AFTER_DATA;
`ifdef UART_ECHO_PARITY_EN
                 txd_n      = tx_par;
`else
                 txd_n      = 1'b1;
`endif
               end else begin
                 txd_n = tx_shift[1];
               end
             end
`ifdef UART_ECHO_PARITY_EN
      PARITY: if (tx_cnt == DIV_LAST) begin
                tx_tick    = 1'b1;
                tx_state_n = STOP;
                txd_n      = 1'b1;
              end
`endif
      STOP:  if (tx_cnt == STOP_LAST) begin
               tx_tick    = 1'b1;
               tx_state_n = IDLE;
               txd_n      = 1'b1;
             end
      default: begin
        tx_state_n = IDLE;
        txd_n      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      txd      <= txd_n;
      tx_cnt   <= (tx_tick || tx_state == IDLE) ? '0 : tx_cnt + 1'b1;
      if (tx_state == START) tx_bit <= '0;
      else if (tx_state == DATA && tx_tick) tx_bit <= tx_bit + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (tx_pop) tx_shift <= fifo_dout;
    else if (tx_state == DATA && tx_tick) tx_shift <= tx_shift >> 1;
`ifdef UART_ECHO_PARITY_EN
    if (tx_pop) tx_par <= (^fifo_dout) ^ 1'(PARITY_ODD);
`endif
  end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// tb_uart_echo_fifo: directed bench for uart_echo_fifo with a byte scoreboard on the TX line.
// A fast baud rate (DIV = 32) keeps the run short; every other setting follows the test plan.
module tb_uart_echo_fifo;
  localparam int CLK_HZ = 100_000_000;
  localparam int BAUD   = 3_125_000;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int HALF   = DIV / 2;
  localparam int DEPTH  = 4;
  localparam int NBITS  = 8;
  localparam int STOPB  = 1;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       rxd = 1'b1;
  logic       tx_hold = 1'b0;
  logic       err_clr = 1'b0;
  logic       txd, rx_overrun, rx_frame_err, rx_parity_err;
  logic [2:0] fifo_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rst_cnt = 0;
  int frames_seen = 0;
  logic [7:0] exp_q[$];
  int start_q[$];
`ifdef UART_ECHO_PARITY_EN
  logic par_flip = 1'b0;
`endif

  uart_echo_fifo #(
    .CLOCK_FREQUENCY (CLK_HZ),
    .BAUD_RATE       (BAUD),
    .DATA_BITS       (NBITS),
    .STOP_BITS       (STOPB),
    .FIFO_DEPTH      (DEPTH),
    .PARITY_ODD      (0)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .rxd           (rxd),
    .txd           (txd),
    .tx_hold       (tx_hold),
    .err_clr       (err_clr),
    .rx_overrun    (rx_overrun),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .fifo_count    (fifo_count)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (!RST_N) rst_cnt <= rst_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // k returns the cycle count at which the start bit was driven.
  task automatic send_frame(input logic [7:0] d, input logic stop, output int k);
    @(negedge CLK);
    rxd = 1'b0;
    k = cyc;
    repeat (DIV) @(negedge CLK);
    for (int i = 0; i < NBITS; i++) begin
      rxd = d[i];
      repeat (DIV) @(negedge CLK);
    end
`ifdef UART_ECHO_PARITY_EN
    rxd = (^d) ^ par_flip;
    repeat (DIV) @(negedge CLK);
`endif
    rxd = stop;
    repeat (DIV) @(negedge CLK);
    rxd = 1'b1;
    repeat (DIV) @(negedge CLK);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t;
    t = 0;
    while (frames_seen < n && t < budget) begin
      @(negedge CLK);
      t++;
    end
    chk("wait_frames_timeout", 32'(frames_seen >= n), 1);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge CLK);
    err_clr = 1'b0;
    @(negedge CLK);
  endtask

  // TX line decoder: frames interrupted by a reset are discarded.
  initial begin : tx_monitor
    logic [7:0] d;
    logic       ok_start, ok_stop;
    logic [7:0] e;
    int         t0, r0;
`ifdef UART_ECHO_PARITY_EN
    logic       p;
`endif
    forever begin
      @(negedge CLK);
      if (RST_N === 1'b1 && txd === 1'b0) begin
        t0 = cyc;
        r0 = rst_cnt;
        repeat (HALF) @(negedge CLK);
        ok_start = (txd === 1'b0);
        for (int i = 0; i < NBITS; i++) begin
          repeat (DIV) @(negedge CLK);
          d[i] = txd;
        end
`ifdef UART_ECHO_PARITY_EN
        repeat (DIV) @(negedge CLK);
        p = txd;
`endif
        repeat (DIV) @(negedge CLK);
        ok_stop = txd;
        if (rst_cnt == r0) begin
          frames_seen++;
          start_q.push_back(t0);
          chk("tx_start_bit", 32'(ok_start), 1);
          chk("tx_stop_bit", 32'(ok_stop), 1);
          if (exp_q.size() == 0) begin
            chk("tx_unexpected_frame", 32'(d), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("tx_data", 32'(d), 32'(e));
`ifdef UART_ECHO_PARITY_EN
            chk("tx_parity", 32'(p), 32'(^e));
`endif
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k, f0, lat;
    logic saw_low;
    logic [7:0] pat [3];
    pat[0] = 8'h00;
    pat[1] = 8'hFF;
    pat[2] = 8'hA3;

    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_txd", 32'(txd), 1);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_overrun", 32'(rx_overrun), 0);
    chk("rst_frame_err", 32'(rx_frame_err), 0);
    chk("rst_parity_err", 32'(rx_parity_err), 0);
    RST_N = 1'b1;
    repeat (2 * DIV) @(negedge CLK);

    // Single echo with latency from the stop-bit sample point
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, k);
    wait_frames(1, 20 * DIV);
    lat = start_q[0] - (k + 2 + HALF + 9 * DIV);
    chk("echo_latency_in_window", 32'(lat >= 3 && lat <= 5), 1);
    chk("echo_no_overrun", 32'(rx_overrun), 0);
    chk("echo_no_frame_err", 32'(rx_frame_err), 0);

    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(pat[i]);
      send_frame(pat[i], 1'b1, k);
    end
    wait_frames(4, 20 * DIV);
    repeat (DIV) @(negedge CLK);
    chk("echo_count_empty", 32'(fifo_count), 0);

    // Overrun while TX is held
    tx_hold = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      if (i <= DEPTH) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, k);
    end
    repeat (4) @(negedge CLK);
    chk("ovr_count_full", 32'(fifo_count), DEPTH);
    chk("ovr_flag", 32'(rx_overrun), 1);
    chk("ovr_no_frame_err", 32'(rx_frame_err), 0);
    chk("hold_blocks_tx", 32'(frames_seen), 4);
    start_q.delete();
    f0 = frames_seen;
    tx_hold = 1'b0;
    wait_frames(f0 + 4, 50 * DIV);
    for (int i = 1; i < 4; i++)
      chk("b2b_spacing", 32'(start_q[i] - start_q[i-1]), (1 + NBITS + STOPB) * DIV + 1);
    chk("drain_count", 32'(fifo_count), 0);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    pulse_clr();
    chk("ovr_cleared", 32'(rx_overrun), 0);

    // Framing error: stop bit low
    f0 = frames_seen;
    send_frame(8'hA5, 1'b0, k);
    repeat (2 * DIV) @(negedge CLK);
    chk("ferr_flag", 32'(rx_frame_err), 1);
    chk("ferr_no_push", 32'(fifo_count), 0);
    chk("ferr_no_echo", 32'(frames_seen), 32'(f0));
    pulse_clr();
    chk("ferr_cleared", 32'(rx_frame_err), 0);

    // Glitch shorter than half a bit
    @(negedge CLK);
    rxd = 1'b0;
    repeat (DIV / 4) @(negedge CLK);
    rxd = 1'b1;
    repeat (12 * DIV) @(negedge CLK);
    chk("glitch_no_push", 32'(fifo_count), 0);
    chk("glitch_no_frame_err", 32'(rx_frame_err), 0);
    chk("glitch_no_overrun", 32'(rx_overrun), 0);
    chk("glitch_no_echo", 32'(frames_seen), 32'(f0));

    // Reset during TX of 0x3C (bit 0 is on the line when send_frame returns)
    send_frame(8'h3C, 1'b1, k);
    chk("tx_busy_before_reset", 32'(txd), 0);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    chk("rst_mid_txd", 32'(txd), 1);
    chk("rst_mid_count", 32'(fifo_count), 0);
    saw_low = 1'b0;
    repeat (15 * DIV) begin
      @(negedge CLK);
      if (txd !== 1'b1) saw_low = 1'b1;
    end
    chk("rst_no_residual_txd", 32'(saw_low), 0);
    chk("rst_no_residual_frame", 32'(frames_seen), 32'(f0));

    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, k);
    wait_frames(f0 + 1, 20 * DIV);

`ifdef UART_ECHO_PARITY_EN
    // Even parity: wrong parity bit discarded, right one echoed
    f0 = frames_seen;
    repeat (DIV) @(negedge CLK);
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, k);
    par_flip = 1'b0;
    repeat (2 * DIV) @(negedge CLK);
    chk("par_err_flag", 32'(rx_parity_err), 1);
    chk("par_err_no_push", 32'(fifo_count), 0);
    chk("par_err_no_echo", 32'(frames_seen), 32'(f0));
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, k);
    wait_frames(f0 + 1, 20 * DIV);
`endif

    repeat (2 * DIV) @(negedge CLK);
    chk("final_scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_echo_fifo.md
# uart_echo_fifo

Parametrised UART loopback engine: receives serial frames on `rxd`, buffers them in a FIFO, and retransmits them on `txd`. It adds configurable data width, FIFO depth, stop-bit count, and transmit flow control. It also reports sticky error status: overrun, framing and optional parity. It sits directly under the board top between the PMOD/GPIO UART pins and the status LEDs.

## Interface
- `CLOCK_FREQUENCY`, 100_000_000: `CLK` frequency in Hz.
- `BAUD_RATE`, 115200: line rate; bit period `DIV = CLOCK_FREQUENCY / BAUD_RATE` (integer, truncated, must be ≥ 16).
- `DATA_BITS`, 8: payload bits per frame, 5–9.
- `STOP_BITS`, 1: transmitted stop bits, 1 or 2. RX checks the first stop bit only.
- `FIFO_DEPTH`, 16: entries, power of two, ≥ 2.
- `PARITY_ODD`, 0: 0 = even, 1 = odd. Used only with the parity macro.
- `CLK`, in, 1: sole clock.
- `RST_N`, in, 1: reset, synchronous, active-low.
- `rxd`, in, 1: asynchronous serial input, idle high.
- `txd`, out, 1: serial output, idle high.
- `tx_hold`, in, 1: while high, no new TX frame starts. A frame in flight completes.
- `err_clr`, in, 1: single-cycle pulse that clears all sticky flags.
- `rx_overrun`, out, 1: sticky; a byte was dropped because the FIFO was full.
- `rx_frame_err`, out, 1: sticky; stop bit was sampled low.
- `rx_parity_err`, out, 1: sticky; parity mismatch. Constant 0 without the macro.
- `fifo_count`, out, `$clog2(FIFO_DEPTH)+1`: current occupancy.

## Operation
- **RX input conditioning:** `rxd` passes through a 2-FF synchronizer. RX arms only after the synchronized line has been high for one full bit period.
- **RX states:**
  - `IDLE`: a falling edge moves to `START`.
  - `START`: waits DIV/2 cycles, then samples. Low moves to `DATA`. High is a glitch and returns to `IDLE` with no flag set.
  - `DATA`: samples every DIV cycles, `DATA_BITS` samples, LSB first.
  - `PARITY`: present only with the macro.
  - `STOP`: samples the stop bit, then returns to `IDLE`.
- **RX outcome at the stop sample:**
  - Stop = 1 and parity good: push the byte.
  - Stop = 0: discard the byte and set `rx_frame_err`.
  - Parity bad: discard the byte and set `rx_parity_err`. Framing takes precedence if both are bad.
- **Push into a full FIFO:** the byte is dropped and `rx_overrun` is set. Fullness is judged on occupancy *before* any same-cycle pop, so push-at-full is dropped even if a pop occurs in the same cycle.
- **TX states:**
  - `IDLE`: when the FIFO is non-empty and `tx_hold` = 0, pop and go to `START`.
  - `START`: drives low for DIV cycles.
  - `DATA`: drives `DATA_BITS` bits, LSB first.
  - `PARITY`: present only with the macro.
  - `STOP`: drives high for `STOP_BITS`×DIV cycles, then returns to `IDLE`.
- **Flags:** all flags are sticky until `err_clr` or reset. If `err_clr` and a new error occur in the same cycle, the flag ends up set.

## Timing
- **Reset values:** `txd` = 1, all flags = 0, `fifo_count` = 0, both FSMs in `IDLE`, FIFO pointers = 0. Values apply at the first `CLK` edge with `RST_N` low.
- **Reset mid-frame:** any partial RX or TX frame is lost. `txd` returns high on the reset edge. RX re-arms per the idle-high rule.
- **Input latency:** `rxd` to synchronized sample is 2 cycles.
- **Push and count:** push occurs on the cycle after the stop sample. `fifo_count` reflects it one cycle later.
- **Pop to start bit:** a pop occurs in the first `IDLE` cycle that meets the conditions. `txd` goes low on the next cycle.
- **Count arithmetic:** simultaneous push and pop leaves `fifo_count` unchanged. Pointers wrap modulo `FIFO_DEPTH`, and the extra count bit distinguishes full from empty.
- **Back-to-back TX:** there is no idle gap between TX frames beyond the single `IDLE` cycle.

## Configuration
- **`UART_ECHO_PARITY_EN` defined:**
  - RX expects one parity bit after the data and checks it against `PARITY_ODD`.
  - TX generates the same parity bit.
  - `rx_parity_err` is live.
- **`UART_ECHO_PARITY_EN` undefined:**
  - No parity bit is sent or expected.
  - The `PARITY` states are absent.
  - `rx_parity_err` is tied to 0.

## Structure
- **Package `uart_pkg`:** holds the RX/TX state enums (`IDLE`, `START`, `DATA`, `PARITY`, `STOP`) and the DIV computation as a constant function.
- **Sub-module `uart_sync_fifo`:** a single-clock, parametrised-width/depth FIFO with push/pop/full/empty/count. The RX and TX FSMs stay in the top-level module.

## Test plan
All scenarios use 100 MHz, 115200 baud (DIV = 868), `DATA_BITS` = 8, `FIFO_DEPTH` = 4, `STOP_BITS` = 1.

1. **Single echo:** send 0x55 → `txd` emits frame 0x55. The start bit falls 4 cycles ±1 after the RX stop-sample. No flags set.
2. **Overrun:** hold `tx_hold` = 1 and send 0x01–0x06 → `fifo_count` = 4 and `rx_overrun` = 1. Release → echoes 0x01–0x04 only, back-to-back.
3. **Framing error:** send 0xA5 with stop bit low → no echo, `rx_frame_err` = 1. Pulse `err_clr` → flag = 0.
4. **Glitch rejection:** drive a 100-cycle low pulse on `rxd` → no push and no flags.
5. **Reset mid-frame:** assert `RST_N` = 0 for 1 cycle mid-TX of 0x3C → `txd` = 1 the next cycle, `fifo_count` = 0, and there is no residual output.
6. **Parity (macro, even):** send 0x07 with parity bit 0 → discarded and `rx_parity_err` = 1. Send 0x07 with parity bit 1 → echoed with parity bit 1.
